// File: rtl/instr_register_pipe.sv
// -----------------------------------------------------------------------------
// instr_register_pipe
//
// This block stores instructions together with their ALU results. It sits
// between an instruction generator and any consumer of the stored entries.
//
// Each write passes through one registered execute stage. The result is
// computed from that stage. On the next rising edge the opcode, the operands,
// the result and the divide-by-zero flag are committed to the addressed entry.
// Every entry carries a valid bit, and an occupancy counter tracks how many
// entries are valid. A read that addresses the entry being committed on the
// same edge returns the new data.
//
// Request semantics: load_en and read_en are single-cycle requests with no
// backpressure. The block accepts every edge on which one of them is high.
// A read answers one cycle later with a one-cycle rd_valid pulse. Between
// pulses the rd_* data outputs hold their last values.
//
// Ports:
//   clk            clock, all state on rising edge
//   reset_n        asynchronous active-low reset
//   load_en        write request
//   write_pointer  write address
//   opcode         ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD (0..7)
//   operand_a/b    signed operands, OP_WIDTH bits
//   read_en        read request
//   read_pointer   read address
//   rd_valid       one-cycle pulse, read data valid
//   rd_hit         the addressed entry was valid
//   rd_opcode/rd_op_a/rd_op_b/rd_result/rd_div_by_zero  stored entry
//   valid_count    number of valid entries
//   full           valid_count == DEPTH
// -----------------------------------------------------------------------------
module instr_register_pipe #(
    parameter int OP_WIDTH = 32,
    parameter int DEPTH    = 32,
    localparam int PTR_W   = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load_en,
    input  logic [PTR_W-1:0]      write_pointer,
    input  logic [2:0]            opcode,
    input  logic [OP_WIDTH-1:0]   operand_a,
    input  logic [OP_WIDTH-1:0]   operand_b,
    input  logic                  read_en,
    input  logic [PTR_W-1:0]      read_pointer,
    output logic                  rd_valid,
    output logic                  rd_hit,
    output logic [2:0]            rd_opcode,
    output logic [OP_WIDTH-1:0]   rd_op_a,
    output logic [OP_WIDTH-1:0]   rd_op_b,
    output logic [2*OP_WIDTH-1:0] rd_result,
    output logic                  rd_div_by_zero,
    output logic [PTR_W:0]        valid_count,
    output logic                  full
);

    localparam int RW = 2 * OP_WIDTH;
    localparam logic [PTR_W:0] DEPTH_W = (PTR_W + 1)'(DEPTH);

    localparam logic [2:0] OP_ZERO  = 3'd0;
    localparam logic [2:0] OP_PASSA = 3'd1;
    localparam logic [2:0] OP_PASSB = 3'd2;
    localparam logic [2:0] OP_ADD   = 3'd3;
    localparam logic [2:0] OP_SUB   = 3'd4;
    localparam logic [2:0] OP_MULT  = 3'd5;
    localparam logic [2:0] OP_DIV   = 3'd6;
    localparam logic [2:0] OP_MOD   = 3'd7;

    // Execute stage
    logic                ex_valid;
    logic [PTR_W-1:0]    ex_ptr;
    logic [2:0]          ex_opcode;
    logic [OP_WIDTH-1:0] ex_a;
    logic [OP_WIDTH-1:0] ex_b;

    // Storage. Only the valid bits are reset. An entry whose valid bit is
    // clear is never returned, so stale data is invisible.
    logic [DEPTH-1:0]    mem_valid;
    logic [2:0]          mem_opcode [DEPTH];
    logic [OP_WIDTH-1:0] mem_a      [DEPTH];
    logic [OP_WIDTH-1:0] mem_b      [DEPTH];
    logic [RW-1:0]       mem_result [DEPTH];
    logic                mem_dbz    [DEPTH];

    // ALU, evaluated from the execute stage
    logic signed [RW-1:0] a_ext;
    logic signed [RW-1:0] b_ext;
    logic signed [RW-1:0] div_b;
    logic signed [RW-1:0] quot;
    logic signed [RW-1:0] rem;
    logic                 b_zero;
    logic [RW-1:0]        alu_result;
    logic                 alu_dbz;

    assign a_ext  = {{OP_WIDTH{ex_a[OP_WIDTH-1]}}, ex_a};
    assign b_ext  = {{OP_WIDTH{ex_b[OP_WIDTH-1]}}, ex_b};
    assign b_zero = (ex_b == '0);
    // The divider always sees a non-zero divisor, so it never produces X.
    // The zero-divisor case is overridden below.
    assign div_b  = b_zero ? {{(RW-1){1'b0}}, 1'b1} : b_ext;
    // Signed / truncates toward zero, and % takes the sign of the dividend.
    assign quot   = a_ext / div_b;
    assign rem    = a_ext % div_b;

    always_comb begin
        alu_result = '0;
        alu_dbz    = 1'b0;
        case (ex_opcode)
            OP_ZERO:  alu_result = '0;
            OP_PASSA: alu_result = a_ext;
            OP_PASSB: alu_result = b_ext;
            OP_ADD:   alu_result = a_ext + b_ext;
            OP_SUB:   alu_result = a_ext - b_ext;
            // The low RW bits of an RW x RW product are the full signed
            // product of the two OP_WIDTH operands.
            OP_MULT:  alu_result = a_ext * b_ext;
            OP_DIV: begin
                alu_result = b_zero ? '0 : quot;
                alu_dbz    = b_zero;
            end
            OP_MOD: begin
                alu_result = b_zero ? '0 : rem;
                alu_dbz    = b_zero;
            end
            default: alu_result = '0;
        endcase
    end

    logic wr_in_range;
    logic rd_in_range;
    logic fwd;

    assign wr_in_range = ({1'b0, write_pointer} < DEPTH_W);
    assign rd_in_range = ({1'b0, read_pointer} < DEPTH_W);
    // The entry being committed on this edge is not yet in storage.
    assign fwd         = ex_valid && (ex_ptr == read_pointer);

    assign full = (valid_count == DEPTH_W);

    // Data commit. There is no reset here; the valid bits gate visibility.
    always_ff @(posedge clk) begin
        if (ex_valid) begin
            mem_opcode[ex_ptr] <= ex_opcode;
            mem_a[ex_ptr]      <= ex_a;
            mem_b[ex_ptr]      <= ex_b;
            mem_result[ex_ptr] <= alu_result;
            mem_dbz[ex_ptr]    <= alu_dbz;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid       <= 1'b0;
            ex_ptr         <= '0;
            ex_opcode      <= '0;
            ex_a           <= '0;
            ex_b           <= '0;
            mem_valid      <= '0;
            valid_count    <= '0;
            rd_valid       <= 1'b0;
            rd_hit         <= 1'b0;
            rd_opcode      <= '0;
            rd_op_a        <= '0;
            rd_op_b        <= '0;
            rd_result      <= '0;
            rd_div_by_zero <= 1'b0;
        end else begin
            // A write to an address beyond DEPTH never enters the execute
            // stage, so it is dropped.
            ex_valid <= load_en && wr_in_range;
            if (load_en) begin
                ex_ptr    <= write_pointer;
                ex_opcode <= opcode;
                ex_a      <= operand_a;
                ex_b      <= operand_b;
            end

            if (ex_valid) begin
                mem_valid[ex_ptr] <= 1'b1;
                if (!mem_valid[ex_ptr]) begin
                    valid_count <= valid_count + 1'b1;
                end
            end

            if (read_en) begin
                rd_valid <= 1'b1;
                if (fwd) begin
                    rd_hit         <= 1'b1;
                    rd_opcode      <= ex_opcode;
                    rd_op_a        <= ex_a;
                    rd_op_b        <= ex_b;
                    rd_result      <= alu_result;
                    rd_div_by_zero <= alu_dbz;
                end else if (rd_in_range && mem_valid[read_pointer]) begin
                    rd_hit         <= 1'b1;
                    rd_opcode      <= mem_opcode[read_pointer];
                    rd_op_a        <= mem_a[read_pointer];
                    rd_op_b        <= mem_b[read_pointer];
                    rd_result      <= mem_result[read_pointer];
                    rd_div_by_zero <= mem_dbz[read_pointer];
                end else begin
                    rd_hit         <= 1'b0;
                    rd_opcode      <= '0;
                    rd_op_a        <= '0;
                    rd_op_b        <= '0;
                    rd_result      <= '0;
                    rd_div_by_zero <= 1'b0;
                end
            end else begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_register_pipe.sv
// -----------------------------------------------------------------------------
// tb_instr_register_pipe
//
// Directed testbench for instr_register_pipe with the default parameters
// (32-bit operands, 32 entries). The driver tasks change inputs 1 ns after a
// rising edge. Outputs are sampled at the same point, away from the edge.
// Every read pushes its hand-computed expected result into exp_q and then pops
// it for comparison.
// -----------------------------------------------------------------------------
module tb_instr_register_pipe;

    localparam logic [2:0] OP_ZERO  = 3'd0;
    localparam logic [2:0] OP_PASSA = 3'd1;
    localparam logic [2:0] OP_PASSB = 3'd2;
    localparam logic [2:0] OP_ADD   = 3'd3;
    localparam logic [2:0] OP_SUB   = 3'd4;
    localparam logic [2:0] OP_MULT  = 3'd5;
    localparam logic [2:0] OP_DIV   = 3'd6;
    localparam logic [2:0] OP_MOD   = 3'd7;

    logic        clk;
    logic        reset_n;
    logic        load_en;
    logic [4:0]  write_pointer;
    logic [2:0]  opcode;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        read_en;
    logic [4:0]  read_pointer;
    logic        rd_valid;
    logic        rd_hit;
    logic [2:0]  rd_opcode;
    logic [31:0] rd_op_a;
    logic [31:0] rd_op_b;
    logic [63:0] rd_result;
    logic        rd_div_by_zero;
    logic [5:0]  valid_count;
    logic        full;

    logic [63:0] exp_q [$];
    int          n_cmp;
    int          n_err;

    instr_register_pipe dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .load_en        (load_en),
        .write_pointer  (write_pointer),
        .opcode         (opcode),
        .operand_a      (operand_a),
        .operand_b      (operand_b),
        .read_en        (read_en),
        .read_pointer   (read_pointer),
        .rd_valid       (rd_valid),
        .rd_hit         (rd_hit),
        .rd_opcode      (rd_opcode),
        .rd_op_a        (rd_op_a),
        .rd_op_b        (rd_op_b),
        .rd_result      (rd_result),
        .rd_div_by_zero (rd_div_by_zero),
        .valid_count    (valid_count),
        .full           (full)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle with the given requests. On return the time is 1 ns
    // after the edge, and the requests have been dropped.
    task automatic drive(input logic le, input logic [4:0] wp, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic re, input logic [4:0] rp);
        load_en       = le;
        write_pointer = wp;
        opcode        = op;
        operand_a     = a;
        operand_b     = b;
        read_en       = re;
        read_pointer  = rp;
        @(posedge clk);
        #1;
        load_en = 1'b0;
        read_en = 1'b0;
    endtask

    task automatic wr(input logic [4:0] wp, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b);
        drive(1'b1, wp, op, a, b, 1'b0, 5'd0);
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, OP_ZERO, 32'd0, 32'd0, 1'b0, 5'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] rp, input logic exp_hit,
                          input logic [63:0] exp_res, input logic exp_dbz);
        exp_q.push_back(exp_res);
        drive(1'b0, 5'd0, OP_ZERO, 32'd0, 32'd0, 1'b1, rp);
        check({tag, "_valid"}, rd_valid, 1'b1);
        check({tag, "_hit"}, rd_hit, exp_hit);
        check({tag, "_result"}, rd_result, exp_q.pop_front());
        check({tag, "_dbz"}, rd_div_by_zero, exp_dbz);
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        reset_n       = 1'b0;
        load_en       = 1'b0;
        read_en       = 1'b0;
        write_pointer = '0;
        read_pointer  = '0;
        opcode        = '0;
        operand_a     = '0;
        operand_b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_rd_result", rd_result, 64'd0);
        check("rst_count", valid_count, 6'd0);
        check("rst_full", full, 1'b0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: read of an unwritten entry
        rd_chk("t1", 5'd5, 1'b0, 64'd0, 1'b0);
        check("t1_opcode", rd_opcode, 3'd0);
        check("t1_count", valid_count, 6'd0);
        check("t1_full", full, 1'b0);

        // 2: ADD -7 + 5, read two cycles after the write
        wr(5'd3, OP_ADD, -32'sd7, 32'sd5);
        idle();
        rd_chk("t2", 5'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        check("t2_opcode", rd_opcode, OP_ADD);
        check("t2_op_a", rd_op_a, 32'hFFFF_FFF9);
        check("t2_op_b", rd_op_b, 32'd5);
        check("t2_count", valid_count, 6'd1);
        // With no read, rd_valid drops and the data outputs hold.
        idle();
        check("t2_hold_valid", rd_valid, 1'b0);
        check("t2_hold_result", rd_result, 64'hFFFF_FFFF_FFFF_FFFE);

        // 3: back-to-back writes, wide MULT and SUB without wrap
        wr(5'd1, OP_MULT, 32'h7FFF_FFFF, 32'd2);
        wr(5'd2, OP_SUB, 32'h8000_0000, 32'd1);
        rd_chk("t3_mult", 5'd1, 1'b1, 64'h0000_0000_FFFF_FFFE, 1'b0);
        rd_chk("t3_sub", 5'd2, 1'b1, 64'hFFFF_FFFF_7FFF_FFFF, 1'b0);
        check("t3_count", valid_count, 6'd3);

        // 4: DIV by zero, MOD and DIV of negative numbers
        wr(5'd4, OP_DIV, -32'sd15, 32'd0);
        wr(5'd5, OP_MOD, -32'sd15, 32'sd4);
        wr(5'd6, OP_DIV, -32'sd15, 32'sd4);
        idle();
        rd_chk("t4_div0", 5'd4, 1'b1, 64'd0, 1'b1);
        rd_chk("t4_mod", 5'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        rd_chk("t4_div", 5'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        check("t4_count", valid_count, 6'd6);

        // 5: forwarding. The read on the capture edge misses. The read on the
        // commit edge sees the new entry.
        drive(1'b1, 5'd7, OP_PASSA, 32'd42, 32'd0, 1'b1, 5'd7);
        check("t5_early_hit", rd_hit, 1'b0);
        check("t5_early_result", rd_result, 64'd0);
        rd_chk("t5_fwd", 5'd7, 1'b1, 64'd42, 1'b0);
        check("t5_count", valid_count, 6'd7);

        // 6: fill, overwrite, then reset mid-sequence
        for (int i = 0; i < 32; i++) begin
            wr(5'(i), OP_ADD, 32'(i), 32'd1);
        end
        idle();
        check("t6_count_full", valid_count, 6'd32);
        check("t6_full", full, 1'b1);
        rd_chk("t6_rd31", 5'd31, 1'b1, 64'd32, 1'b0);
        wr(5'd0, OP_PASSB, 32'd0, 32'd99);
        idle();
        check("t6_count_ovw", valid_count, 6'd32);
        rd_chk("t6_rd0", 5'd0, 1'b1, 64'd99, 1'b0);
        // The execute stage now holds a write to addr 0, and reset drops it.
        wr(5'd0, OP_PASSA, 32'd5, 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_count", valid_count, 6'd0);
        check("t6_rst_full", full, 1'b0);
        check("t6_rst_rd_result", rd_result, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        idle();
        rd_chk("t6_after_rst", 5'd0, 1'b0, 64'd0, 1'b0);
        check("t6_after_rst_count", valid_count, 6'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_register_pipe.md
Name: instr_register_pipe

Overview:
- Parameterised successor of the instruction register: configurable depth and operand width.
- Each written instruction's ALU result is computed in a registered execute stage and stored alongside it.
- Adds per-entry valid tracking, an occupancy counter, divide-by-zero flagging and write-to-read forwarding.
- Sits between the instruction generator (test or sequencer) and any consumer of stored instructions and results.

Parameters:
- OP_WIDTH, 32: signed operand width; result width is 2*OP_WIDTH.
- DEPTH, 32: number of register locations; must be at least 2.
- PTR_W, $clog2(DEPTH): pointer width, derived; not overridden.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load_en  in  1  write request, sampled each rising edge.
- write_pointer  in  PTR_W  write address.
- opcode  in  3  operation: ZERO=0, PASSA=1, PASSB=2, ADD=3, SUB=4, MULT=5, DIV=6, MOD=7.
- operand_a  in  OP_WIDTH  signed operand A.
- operand_b  in  OP_WIDTH  signed operand B.
- read_en  in  1  read request, sampled each rising edge.
- read_pointer  in  PTR_W  read address.
- rd_valid  out  1  one-cycle pulse: read data valid.
- rd_hit  out  1  addressed entry was valid.
- rd_opcode  out  3  stored opcode.
- rd_op_a  out  OP_WIDTH  stored operand A.
- rd_op_b  out  OP_WIDTH  stored operand B.
- rd_result  out  2*OP_WIDTH  stored result.
- rd_div_by_zero  out  1  stored DIV/MOD-by-zero flag.
- valid_count  out  PTR_W+1  number of valid entries.
- full  out  1  valid_count == DEPTH.

Behaviour:
- Reset, asynchronous on reset_n=0:
  - All outputs go to 0; valid_count=0; full=0.
  - All entry valid bits and the execute-stage valid are cleared.
  - Array data need not be cleared; invalid entries read as zero.
  - An in-flight write is dropped.
- Write pipeline:
  - Edge N with load_en=1: capture opcode, operands and write_pointer into the execute stage (ex_valid=1).
  - Between edges N and N+1: compute the result combinationally from the execute stage.
  - Edge N+1: commit opcode, operands, result, dbz flag and valid bit to the addressed entry.
- Back-to-back writes on consecutive edges are supported at full throughput.
- Arithmetic, with operands sign-extended to 2*OP_WIDTH:
  - ZERO: 0.
  - PASSA: A. PASSB: B.
  - ADD: A+B. SUB: A-B. MULT: full signed A*B.
  - DIV: signed quotient, truncating toward zero.
  - MOD: signed remainder, taking the sign of A.
  - DIV or MOD with B==0: result 0, dbz=1.
  - dbz=0 in every other case.
- Read path:
  - Edge M with read_en=1: register the outputs and pulse rd_valid for one cycle; latency is 1.
  - With read_en=0, rd_valid=0 and the data outputs hold their last values.
- Unwritten location: rd_hit=0 and all rd_* data outputs are 0.
- Forwarding: if the execute stage commits to address X on the same edge as a read of X, the read returns the new entry with rd_hit=1.
- Occupancy:
  - A commit to an invalid entry increments valid_count.
  - An overwrite of a valid entry leaves valid_count unchanged.
  - valid_count never exceeds DEPTH.
  - full is combinational from valid_count.
- Writes are always accepted, including when full; they overwrite.
- Pointers at or above DEPTH (when DEPTH is not a power of two): the write is ignored and the read returns rd_hit=0.

Test Plan:
1. Reset, then read_en with read_pointer=5 → next cycle rd_valid=1, rd_hit=0, rd_result=0, valid_count=0, full=0.
2. Write addr 3, ADD, A=-7, B=5; read addr 3 two cycles later → rd_result=64'hFFFF_FFFF_FFFF_FFFE, rd_hit=1, rd_div_by_zero=0, valid_count=1.
3. Write MULT A=32'h7FFF_FFFF B=2 → rd_result=64'h0000_0000_FFFF_FFFE. Write SUB A=-2^31 B=1 → rd_result=-2147483649 (no wrap).
4. DIV A=-15 B=0 → rd_result=0, rd_div_by_zero=1. MOD A=-15 B=4 → rd_result=-3, dbz=0. DIV A=-15 B=4 → rd_result=-3.
5. Forwarding: write addr 7 (PASSA, A=42) at edge N, read_en addr 7 at edge N+1 → rd_result=42, rd_hit=1. Read addr 7 at edge N (before commit) → rd_hit=0.
6. Write all 32 addresses → valid_count=32, full=1. Overwrite addr 0 → count stays 32. Pulse reset_n low mid-sequence → valid_count=0 and full=0 immediately; subsequent read of addr 0 → rd_hit=0.
